// File: rtl/ex_operand_stage.sv
// rtl/ex_operand_stage.sv - ID/EX operand stage: pipeline register, RAW forwarding, hazard stall (EX_FWD_EN selects forwarding)
module ex_operand_stage #(
  parameter int DATA_WIDTH = 16,
  parameter int OPER_WIDTH = 4,
  parameter int REG_ADDR_W = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_rs_used,
  input  logic                  id_rt_used,
  input  logic [DATA_WIDTH-1:0] id_rs_data,
  input  logic [DATA_WIDTH-1:0] id_rt_data,
  input  logic [DATA_WIDTH-1:0] id_imm,
  input  logic                  id_use_imm,
  input  logic [OPER_WIDTH-1:0] id_oper,
  input  logic                  id_inv_a,
  input  logic                  id_inv_b,
  input  logic                  id_cin,
  input  logic                  id_sign,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_wr_en,
  input  logic                  id_is_load,
  input  logic                  mem_stall,
  input  logic                  flush,
  input  logic [REG_ADDR_W-1:0] exm_rd,
  input  logic                  exm_wr_en,
  input  logic [DATA_WIDTH-1:0] exm_result,
  input  logic [REG_ADDR_W-1:0] mwb_rd,
  input  logic                  mwb_wr_en,
  input  logic [DATA_WIDTH-1:0] mwb_data,
  output logic                  id_stall,
  output logic                  ex_valid,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  ex_wr_en,
  output logic                  ex_is_load,
  output logic [DATA_WIDTH-1:0] alu_in_a,
  output logic [DATA_WIDTH-1:0] alu_in_b,
  output logic [OPER_WIDTH-1:0] alu_oper,
  output logic                  alu_inv_a,
  output logic                  alu_inv_b,
  output logic                  alu_cin,
  output logic                  alu_sign,
  output logic [DATA_WIDTH-1:0] ex_store_data
);

  logic                  r_valid;
  logic [REG_ADDR_W-1:0] r_rs;
  logic [REG_ADDR_W-1:0] r_rt;
  logic                  r_rs_used;
  logic                  r_rt_used;
  logic [DATA_WIDTH-1:0] r_rs_data;
  logic [DATA_WIDTH-1:0] r_rt_data;
  logic [DATA_WIDTH-1:0] r_imm;
  logic                  r_use_imm;
  logic [OPER_WIDTH-1:0] r_oper;
  logic                  r_inv_a;
  logic                  r_inv_b;
  logic                  r_cin;
  logic                  r_sign;
  logic [REG_ADDR_W-1:0] r_rd;
  logic                  r_wr_en;
  logic                  r_is_load;

  logic                  hazard;
  logic [DATA_WIDTH-1:0] src_a;
  logic [DATA_WIDTH-1:0] src_b;

  // Pipeline register: reset > flush > memory hold > load bubble > capture
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid   <= 1'b0;
      r_rs      <= '0;
      r_rt      <= '0;
      r_rs_used <= 1'b0;
      r_rt_used <= 1'b0;
      r_rs_data <= '0;
      r_rt_data <= '0;
      r_imm     <= '0;
      r_use_imm <= 1'b0;
      r_oper    <= '0;
      r_inv_a   <= 1'b0;
      r_inv_b   <= 1'b0;
      r_cin     <= 1'b0;
      r_sign    <= 1'b0;
      r_rd      <= '0;
      r_wr_en   <= 1'b0;
      r_is_load <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (!mem_stall) begin
      // A stalled consumer still loads its fields, but as a bubble
      r_valid   <= id_valid & ~id_stall;
      r_rs      <= id_rs;
      r_rt      <= id_rt;
      r_rs_used <= id_rs_used;
      r_rt_used <= id_rt_used;
      r_rs_data <= id_rs_data;
      r_rt_data <= id_rt_data;
      r_imm     <= id_imm;
      r_use_imm <= id_use_imm;
      r_oper    <= id_oper;
      r_inv_a   <= id_inv_a;
      r_inv_b   <= id_inv_b;
      r_cin     <= id_cin;
      r_sign    <= id_sign;
      r_rd      <= id_rd;
      r_wr_en   <= id_wr_en;
      r_is_load <= id_is_load;
    end
  end

`ifdef EX_FWD_EN
  // Only a load sitting in EX cannot be forwarded in time; everything else is bypassed
  always_comb begin
    hazard = id_valid & r_valid & r_is_load & r_wr_en &
             ((id_rs_used & (id_rs == r_rd)) | (id_rt_used & (id_rt == r_rd)));
  end

  // Operand bypass: EX/MEM is the younger result and beats MEM/WB
  always_comb begin
    src_a = r_rs_data;
    src_b = r_rt_data;
    if (r_rs_used && exm_wr_en && (exm_rd == r_rs)) begin
      src_a = exm_result;
    end else if (r_rs_used && mwb_wr_en && (mwb_rd == r_rs)) begin
      src_a = mwb_data;
    end
    if (r_rt_used && exm_wr_en && (exm_rd == r_rt)) begin
      src_b = exm_result;
    end else if (r_rt_used && mwb_wr_en && (mwb_rd == r_rt)) begin
      src_b = mwb_data;
    end
  end
`else
  // Without bypassing, wait until any pending writer reaches MEM/WB (regfile bypasses WB)
  always_comb begin
    hazard = id_valid &
             ((r_valid & r_wr_en &
               ((id_rs_used & (id_rs == r_rd)) | (id_rt_used & (id_rt == r_rd)))) |
              (exm_wr_en &
               ((id_rs_used & (id_rs == exm_rd)) | (id_rt_used & (id_rt == exm_rd)))));
  end

  // Operands come straight from the registered regfile read
  always_comb begin
    src_a = r_rs_data;
    src_b = r_rt_data;
  end

  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ^{exm_result, mwb_rd, mwb_wr_en, mwb_data,
                               r_rs, r_rt, r_rs_used, r_rt_used};
`endif

  // Squashed instructions never stall; reset keeps the stall low
  always_comb begin
    id_stall = ~rst & ~flush & hazard;
  end

  // Drive ALU and downstream outputs from the pipeline register
  always_comb begin
    ex_valid      = r_valid;
    ex_rd         = r_rd;
    ex_wr_en      = r_valid & r_wr_en;
    ex_is_load    = r_valid & r_is_load;
    alu_in_a      = src_a;
    alu_in_b      = r_use_imm ? r_imm : src_b;
    alu_oper      = r_oper;
    alu_inv_a     = r_inv_a;
    alu_inv_b     = r_inv_b;
    alu_cin       = r_cin;
    alu_sign      = r_sign;
    ex_store_data = src_b;
  end

endmodule

// File: tb/tb_ex_operand_stage.sv
// tb/tb_ex_operand_stage.sv - directed table-driven bench for ex_operand_stage
module tb_ex_operand_stage;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic [2:0]  id_rs, id_rt;
  logic        id_rs_used, id_rt_used;
  logic [15:0] id_rs_data, id_rt_data, id_imm;
  logic        id_use_imm;
  logic [3:0]  id_oper;
  logic        id_inv_a, id_inv_b, id_cin, id_sign;
  logic [2:0]  id_rd;
  logic        id_wr_en, id_is_load;
  logic        mem_stall, flush;
  logic [2:0]  exm_rd;
  logic        exm_wr_en;
  logic [15:0] exm_result;
  logic [2:0]  mwb_rd;
  logic        mwb_wr_en;
  logic [15:0] mwb_data;
  logic        id_stall, ex_valid;
  logic [2:0]  ex_rd;
  logic        ex_wr_en, ex_is_load;
  logic [15:0] alu_in_a, alu_in_b, ex_store_data;
  logic [3:0]  alu_oper;
  logic        alu_inv_a, alu_inv_b, alu_cin, alu_sign;

  int n_checks = 0;
  int n_fail = 0;

  ex_operand_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm), .id_use_imm(id_use_imm),
    .id_oper(id_oper), .id_inv_a(id_inv_a), .id_inv_b(id_inv_b), .id_cin(id_cin), .id_sign(id_sign),
    .id_rd(id_rd), .id_wr_en(id_wr_en), .id_is_load(id_is_load),
    .mem_stall(mem_stall), .flush(flush),
    .exm_rd(exm_rd), .exm_wr_en(exm_wr_en), .exm_result(exm_result),
    .mwb_rd(mwb_rd), .mwb_wr_en(mwb_wr_en), .mwb_data(mwb_data),
    .id_stall(id_stall), .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load),
    .alu_in_a(alu_in_a), .alu_in_b(alu_in_b), .alu_oper(alu_oper),
    .alu_inv_a(alu_inv_a), .alu_inv_b(alu_inv_b), .alu_cin(alu_cin), .alu_sign(alu_sign),
    .ex_store_data(ex_store_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  rs, rt;
    logic        rs_used, rt_used;
    logic [15:0] rs_data, rt_data, imm;
    logic        use_imm;
    logic [3:0]  oper;
    logic [3:0]  ctrl;
    logic [2:0]  rd;
    logic        wr_en, is_load;
    logic [2:0]  x_rd;
    logic        x_wr;
    logic [15:0] x_res;
    logic [2:0]  w_rd;
    logic        w_wr;
    logic [15:0] w_dat;
    logic [15:0] a_fwd, b_fwd, st_fwd;
    logic [15:0] a_raw, b_raw, st_raw;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    id_valid = 1'b0; id_rs = 3'd0; id_rt = 3'd0; id_rs_used = 1'b0; id_rt_used = 1'b0;
    id_rs_data = 16'h0; id_rt_data = 16'h0; id_imm = 16'h0; id_use_imm = 1'b0;
    id_oper = 4'h0; id_inv_a = 1'b0; id_inv_b = 1'b0; id_cin = 1'b0; id_sign = 1'b0;
    id_rd = 3'd0; id_wr_en = 1'b0; id_is_load = 1'b0;
    mem_stall = 1'b0; flush = 1'b0;
    exm_rd = 3'd0; exm_wr_en = 1'b0; exm_result = 16'h0;
    mwb_rd = 3'd0; mwb_wr_en = 1'b0; mwb_data = 16'h0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // rs rt rsu rtu rs_data rt_data imm use_imm oper ctrl rd wr ld | exm | mwb | fwd a b st | raw a b st
    vecs[0] = '{3'd3, 3'd4, 1'b1, 1'b1, 16'h0000, 16'h4444, 16'h0000, 1'b0, 4'h1, 4'b0000, 3'd1, 1'b1, 1'b0,
                3'd3, 1'b1, 16'h1234, 3'd0, 1'b0, 16'h0000,
                16'h1234, 16'h4444, 16'h4444, 16'h0000, 16'h4444, 16'h4444};
    vecs[1] = '{3'd3, 3'd4, 1'b1, 1'b1, 16'h0000, 16'h4444, 16'h0000, 1'b0, 4'h2, 4'b1000, 3'd2, 1'b0, 1'b0,
                3'd3, 1'b1, 16'h1234, 3'd3, 1'b1, 16'hBEEF,
                16'h1234, 16'h4444, 16'h4444, 16'h0000, 16'h4444, 16'h4444};
    vecs[2] = '{3'd2, 3'd5, 1'b1, 1'b1, 16'h0011, 16'h0055, 16'h0000, 1'b0, 4'h3, 4'b0100, 3'd6, 1'b1, 1'b1,
                3'd2, 1'b0, 16'h9999, 3'd5, 1'b1, 16'h00AA,
                16'h0011, 16'h00AA, 16'h00AA, 16'h0011, 16'h0055, 16'h0055};
    vecs[3] = '{3'd1, 3'd6, 1'b1, 1'b1, 16'h0101, 16'h0066, 16'hFFF0, 1'b1, 4'h4, 4'b0010, 3'd7, 1'b1, 1'b0,
                3'd6, 1'b1, 16'h7777, 3'd1, 1'b0, 16'h2222,
                16'h0101, 16'hFFF0, 16'h7777, 16'h0101, 16'hFFF0, 16'h0066};
    vecs[4] = '{3'd3, 3'd0, 1'b0, 1'b1, 16'h0033, 16'h0000, 16'h0000, 1'b0, 4'hF, 4'b1111, 3'd0, 1'b0, 1'b1,
                3'd3, 1'b1, 16'h5555, 3'd0, 1'b1, 16'hABCD,
                16'h0033, 16'hABCD, 16'hABCD, 16'h0033, 16'h0000, 16'h0000};
    vecs[5] = '{3'd4, 3'd4, 1'b1, 1'b1, 16'h0404, 16'h0404, 16'h0000, 1'b0, 4'h6, 4'b0101, 3'd3, 1'b1, 1'b0,
                3'd4, 1'b1, 16'h0E0E, 3'd4, 1'b1, 16'h0B0B,
                16'h0E0E, 16'h0E0E, 16'h0E0E, 16'h0404, 16'h0404, 16'h0404};

    drive_idle();
    // Reset with a valid writer presented
    rst = 1'b1;
    id_valid = 1'b1; id_rs = 3'd1; id_rs_used = 1'b1; id_rs_data = 16'h5555; id_rd = 3'd1; id_wr_en = 1'b1;
    step();
    chk("rst_ex_valid", {15'd0, ex_valid}, 16'h0);
    chk("rst_ex_wr_en", {15'd0, ex_wr_en}, 16'h0);
    chk("rst_alu_in_a", alu_in_a, 16'h0000);
    chk("rst_id_stall", {15'd0, id_stall}, 16'h0);
    step();
    chk("rst2_ex_valid", {15'd0, ex_valid}, 16'h0);
    rst = 1'b0;
    step();
    chk("post_rst_ex_valid", {15'd0, ex_valid}, 16'h1);
    chk("post_rst_alu_in_a", alu_in_a, 16'h5555);
    chk("post_rst_ex_wr_en", {15'd0, ex_wr_en}, 16'h1);
    drive_idle();
    step();

    // Table: capture with sources quiet, then present forwarding sources
    for (int i = 0; i < 6; i++) begin
      vec_t v;
      logic [15:0] ea, eb, es;
      v = vecs[i];
`ifdef EX_FWD_EN
      ea = v.a_fwd; eb = v.b_fwd; es = v.st_fwd;
`else
      ea = v.a_raw; eb = v.b_raw; es = v.st_raw;
`endif
      drive_idle();
      id_valid = 1'b1; id_rs = v.rs; id_rt = v.rt; id_rs_used = v.rs_used; id_rt_used = v.rt_used;
      id_rs_data = v.rs_data; id_rt_data = v.rt_data; id_imm = v.imm; id_use_imm = v.use_imm;
      id_oper = v.oper; {id_inv_a, id_inv_b, id_cin, id_sign} = v.ctrl;
      id_rd = v.rd; id_wr_en = v.wr_en; id_is_load = v.is_load;
      step();
      exm_rd = v.x_rd; exm_wr_en = v.x_wr; exm_result = v.x_res;
      mwb_rd = v.w_rd; mwb_wr_en = v.w_wr; mwb_data = v.w_dat;
      #1;
      chk($sformatf("vec%0d_alu_in_a", i), alu_in_a, ea);
      chk($sformatf("vec%0d_alu_in_b", i), alu_in_b, eb);
      chk($sformatf("vec%0d_store", i), ex_store_data, es);
      chk($sformatf("vec%0d_oper", i), {12'd0, alu_oper}, {12'd0, v.oper});
      chk($sformatf("vec%0d_ctrl", i), {12'd0, alu_inv_a, alu_inv_b, alu_cin, alu_sign}, {12'd0, v.ctrl});
      chk($sformatf("vec%0d_ex_rd", i), {13'd0, ex_rd}, {13'd0, v.rd});
      chk($sformatf("vec%0d_ex_wr_en", i), {15'd0, ex_wr_en}, {15'd0, v.wr_en});
      chk($sformatf("vec%0d_ex_is_load", i), {15'd0, ex_is_load}, {15'd0, v.is_load});
      chk($sformatf("vec%0d_ex_valid", i), {15'd0, ex_valid}, 16'h1);
      drive_idle();
      step();
    end

`ifdef EX_FWD_EN
    // Load-use: one stall, one bubble, consumer forwards from MEM/WB
    drive_idle();
    id_valid = 1'b1; id_rd = 3'd2; id_wr_en = 1'b1; id_is_load = 1'b1;
    step();
    drive_idle();
    id_valid = 1'b1; id_rs = 3'd2; id_rs_used = 1'b1; id_rs_data = 16'h0000; id_rd = 3'd4; id_wr_en = 1'b1;
    #1;
    chk("lu_stall_on", {15'd0, id_stall}, 16'h1);
    step();
    chk("lu_bubble", {15'd0, ex_valid}, 16'h0);
    exm_rd = 3'd2; exm_wr_en = 1'b1; exm_result = 16'hDEAD;
    #1;
    chk("lu_stall_off", {15'd0, id_stall}, 16'h0);
    step();
    exm_wr_en = 1'b0;
    mwb_rd = 3'd2; mwb_wr_en = 1'b1; mwb_data = 16'h00AA;
    #1;
    chk("lu_consumer_valid", {15'd0, ex_valid}, 16'h1);
    chk("lu_consumer_a", alu_in_a, 16'h00AA);
    chk("lu_consumer_rd", {13'd0, ex_rd}, 16'h0004);
`else
    // Non-load writer r5: two stall cycles, then regfile (WB bypass) value
    drive_idle();
    id_valid = 1'b1; id_rd = 3'd5; id_wr_en = 1'b1;
    step();
    drive_idle();
    id_valid = 1'b1; id_rs = 3'd5; id_rs_used = 1'b1; id_rs_data = 16'h0000; id_rd = 3'd1; id_wr_en = 1'b1;
    #1;
    chk("nf_stall_ex", {15'd0, id_stall}, 16'h1);
    step();
    chk("nf_bubble1", {15'd0, ex_valid}, 16'h0);
    exm_rd = 3'd5; exm_wr_en = 1'b1; exm_result = 16'h0055;
    #1;
    chk("nf_stall_exm", {15'd0, id_stall}, 16'h1);
    step();
    chk("nf_bubble2", {15'd0, ex_valid}, 16'h0);
    exm_wr_en = 1'b0;
    mwb_rd = 3'd5; mwb_wr_en = 1'b1; mwb_data = 16'h0055;
    id_rs_data = 16'h0055;
    #1;
    chk("nf_stall_off", {15'd0, id_stall}, 16'h0);
    step();
    chk("nf_consumer_valid", {15'd0, ex_valid}, 16'h1);
    chk("nf_consumer_a", alu_in_a, 16'h0055);
`endif
    drive_idle();
    step();

    // Flush together with mem_stall: flush wins, no hazard stall reported
    id_valid = 1'b1; id_rd = 3'd2; id_wr_en = 1'b1; id_is_load = 1'b1;
    step();
    drive_idle();
    id_valid = 1'b1; id_rs = 3'd2; id_rs_used = 1'b1;
    flush = 1'b1; mem_stall = 1'b1;
    #1;
    chk("flush_id_stall", {15'd0, id_stall}, 16'h0);
    step();
    chk("flush_ex_valid", {15'd0, ex_valid}, 16'h0);

    // Capture an instruction, then hold it through 3 memory-stall cycles
    drive_idle();
    id_valid = 1'b1; id_rs = 3'd1; id_rs_used = 1'b1; id_rs_data = 16'h1357; id_oper = 4'h5;
    id_rd = 3'd3; id_wr_en = 1'b1;
    step();
    chk("hold_pre_a", alu_in_a, 16'h1357);
    chk("hold_pre_valid", {15'd0, ex_valid}, 16'h1);
    mem_stall = 1'b1;
    id_rs_data = 16'hFFFF; id_oper = 4'hA; id_rd = 3'd6;
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("hold%0d_a", c), alu_in_a, 16'h1357);
      chk($sformatf("hold%0d_oper", c), {12'd0, alu_oper}, 16'h0005);
      chk($sformatf("hold%0d_rd", c), {13'd0, ex_rd}, 16'h0003);
      chk($sformatf("hold%0d_valid", c), {15'd0, ex_valid}, 16'h1);
    end
    drive_idle();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
